// File: rtl/alu_seq_if.sv
// Request channel between instruction decode and the ALU sequencer.
// One instruction is offered with req_valid and accepted on a clock edge
// where req_ready is high.
//   master: decode side, drives the request fields, observes req_ready
//   slave : sequencer side, samples the request fields, drives req_ready
interface alu_seq_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_IDX_WIDTH = 4,
  parameter int OPER_WIDTH    = 5
);
  logic                     req_valid;
  logic                     req_ready;
  logic [OPER_WIDTH-1:0]    req_oper;
  logic                     req_is_pair;
  logic                     req_no_wb;
  logic [REG_IDX_WIDTH-1:0] req_ra;
  logic [REG_IDX_WIDTH-1:0] req_rb;
  logic                     req_b_imm;
  logic [DATA_WIDTH-1:0]    req_imm;

  modport master (
    output req_valid, req_oper, req_is_pair, req_no_wb,
           req_ra, req_rb, req_b_imm, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_oper, req_is_pair, req_no_wb,
           req_ra, req_rb, req_b_imm, req_imm,
    output req_ready
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer on the operand/result side of the ALU.
// Accepts one ALU instruction, reads A (one or two registers) and B over a
// single register-file read port, drives the ALU from latched operands,
// captures result and flags, and writes the result back (8-bit or pair).
// Owns the architectural processor-flags register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req (slave)         instruction request handshake and fields
//   rd_idx / rd_data    register-file read port (combinational read)
//   wr_en/wr_idx/wr_data register-file write port
//   alu_*               operands to / results from the ALU
//   flags               architectural flags register
//   flags_load(_val)    external flags write, lower priority than EXEC
//   done                one-cycle pulse when the instruction retires
module alu_seq #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_IDX_WIDTH = 4,
  parameter int OPER_WIDTH    = 5,
  parameter int FLAGS_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_seq_if.slave                 req,
  output logic [REG_IDX_WIDTH-1:0] rd_idx,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     wr_en,
  output logic [REG_IDX_WIDTH-1:0] wr_idx,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [OPER_WIDTH-1:0]    alu_oper,
  output logic [DATA_WIDTH-1:0]    alu_a_lo,
  output logic [DATA_WIDTH-1:0]    alu_a_hi,
  output logic [DATA_WIDTH-1:0]    alu_b,
  output logic [FLAGS_WIDTH-1:0]   alu_flags_in,
  input  logic [DATA_WIDTH-1:0]    alu_out_lo,
  input  logic [DATA_WIDTH-1:0]    alu_out_hi,
  input  logic [FLAGS_WIDTH-1:0]   alu_flags_out,
  output logic [FLAGS_WIDTH-1:0]   flags,
  input  logic                     flags_load,
  input  logic [FLAGS_WIDTH-1:0]   flags_load_val,
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A_LO = 3'd1,
    RD_A_HI = 3'd2,
    RD_B    = 3'd3,
    EXEC    = 3'd4,
    WB_LO   = 3'd5,
    WB_HI   = 3'd6
  } state_t;

  state_t                   state_r;
  logic                     req_ready_r;
  logic [OPER_WIDTH-1:0]    oper_r;
  logic                     is_pair_r;
  logic                     no_wb_r;
  logic [REG_IDX_WIDTH-1:0] ra_r;
  logic [REG_IDX_WIDTH-1:0] rb_r;
  logic                     b_imm_r;
  logic [DATA_WIDTH-1:0]    imm_r;
  logic [DATA_WIDTH-1:0]    a_lo_r;
  logic [DATA_WIDTH-1:0]    a_hi_r;
  logic [DATA_WIDTH-1:0]    b_r;
  logic [DATA_WIDTH-1:0]    result_hi_r;
  logic [FLAGS_WIDTH-1:0]   flags_r;
  logic [REG_IDX_WIDTH-1:0] rd_idx_r;
  logic                     wr_en_r;
  logic [REG_IDX_WIDTH-1:0] wr_idx_r;
  logic [DATA_WIDTH-1:0]    wr_data_r;
  logic                     done_r;

  // Low register of the destination: even register of the pair, or ra itself.
  function automatic logic [REG_IDX_WIDTH-1:0] lo_idx(
    input logic [REG_IDX_WIDTH-1:0] ra,
    input logic                     pair
  );
    logic [REG_IDX_WIDTH-1:0] idx;
    if (pair) begin
      idx = {ra[REG_IDX_WIDTH-1:1], 1'b0};
    end else begin
      idx = ra;
    end
    return idx;
  endfunction

  // High register of a pair: odd register, ra[0] ignored.
  function automatic logic [REG_IDX_WIDTH-1:0] hi_idx(
    input logic [REG_IDX_WIDTH-1:0] ra
  );
    return {ra[REG_IDX_WIDTH-1:1], 1'b1};
  endfunction

  // Sequencer FSM, operand/result latches and the flags register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      oper_r      <= '0;
      is_pair_r   <= 1'b0;
      no_wb_r     <= 1'b0;
      ra_r        <= '0;
      rb_r        <= '0;
      b_imm_r     <= 1'b0;
      imm_r       <= '0;
      a_lo_r      <= '0;
      a_hi_r      <= '0;
      b_r         <= '0;
      result_hi_r <= '0;
      flags_r     <= '0;
      rd_idx_r    <= '0;
      wr_en_r     <= 1'b0;
      wr_idx_r    <= '0;
      wr_data_r   <= '0;
      done_r      <= 1'b0;
    end else begin
      // The ALU result owns the flags in EXEC; an external load then is dropped.
      if (state_r == EXEC) begin
        flags_r <= alu_flags_out;
      end else if (flags_load) begin
        flags_r <= flags_load_val;
      end else begin
        flags_r <= flags_r;
      end

      // rd_idx, wr_* and done are loaded one edge ahead so they are valid
      // throughout the state that uses them.
      case (state_r)
        IDLE: begin
          if (req.req_valid) begin
            oper_r      <= req.req_oper;
            is_pair_r   <= req.req_is_pair;
            no_wb_r     <= req.req_no_wb;
            ra_r        <= req.req_ra;
            rb_r        <= req.req_rb;
            b_imm_r     <= req.req_b_imm;
            imm_r       <= req.req_imm;
            a_hi_r      <= '0;
            rd_idx_r    <= lo_idx(req.req_ra, req.req_is_pair);
            req_ready_r <= 1'b0;
            state_r     <= RD_A_LO;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        RD_A_LO: begin
          a_lo_r <= rd_data;
          if (is_pair_r) begin
            rd_idx_r <= hi_idx(ra_r);
            state_r  <= RD_A_HI;
          end else begin
            rd_idx_r <= rb_r;
            state_r  <= RD_B;
          end
        end
        RD_A_HI: begin
          a_hi_r   <= rd_data;
          rd_idx_r <= rb_r;
          state_r  <= RD_B;
        end
        RD_B: begin
          b_r     <= b_imm_r ? imm_r : rd_data;
          done_r  <= no_wb_r;
          state_r <= EXEC;
        end
        EXEC: begin
          result_hi_r <= alu_out_hi;
          if (no_wb_r) begin
            done_r      <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            wr_en_r   <= 1'b1;
            wr_idx_r  <= lo_idx(ra_r, is_pair_r);
            wr_data_r <= alu_out_lo;
            done_r    <= ~is_pair_r;
            state_r   <= WB_LO;
          end
        end
        WB_LO: begin
          if (is_pair_r) begin
            wr_idx_r  <= hi_idx(ra_r);
            wr_data_r <= result_hi_r;
            done_r    <= 1'b1;
            state_r   <= WB_HI;
          end else begin
            wr_en_r     <= 1'b0;
            done_r      <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        WB_HI: begin
          wr_en_r     <= 1'b0;
          done_r      <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          wr_en_r     <= 1'b0;
          done_r      <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req.req_ready = req_ready_r;
  assign rd_idx        = rd_idx_r;
  assign wr_idx        = wr_idx_r;
  assign wr_data       = wr_data_r;
  // No write or retire may escape in a cycle where reset is asserted.
  assign wr_en         = wr_en_r & ~rst;
  assign done          = done_r & ~rst;
  assign alu_oper      = oper_r;
  assign alu_a_lo      = a_lo_r;
  assign alu_a_hi      = a_hi_r;
  assign alu_b         = b_r;
  assign alu_flags_in  = flags_r;
  assign flags         = flags_r;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [7:0] wr_data;
  logic [4:0] alu_oper;
  logic [7:0] alu_a_lo, alu_a_hi, alu_b;
  logic [3:0] alu_flags_in;
  logic [7:0] alu_out_lo, alu_out_hi;
  logic [3:0] alu_flags_out;
  logic [3:0] flags;
  logic       flags_load;
  logic [3:0] flags_load_val;
  logic       done;

  int checks = 0;
  int errors = 0;

  alu_seq_if #(.DATA_WIDTH(8), .REG_IDX_WIDTH(4), .OPER_WIDTH(5)) req_if ();

  alu_seq #(.DATA_WIDTH(8), .REG_IDX_WIDTH(4), .OPER_WIDTH(5), .FLAGS_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req_if),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .alu_oper(alu_oper), .alu_a_lo(alu_a_lo), .alu_a_hi(alu_a_hi), .alu_b(alu_b),
    .alu_flags_in(alu_flags_in), .alu_out_lo(alu_out_lo), .alu_out_hi(alu_out_hi),
    .alu_flags_out(alu_flags_out), .flags(flags),
    .flags_load(flags_load), .flags_load_val(flags_load_val), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write on rising edge.
  logic [7:0] rf [16];
  assign rd_data = rf[rd_idx];
  always @(posedge clk) if (wr_en) rf[wr_idx] <= wr_data;

  // ALU model: op 1 = 16-bit subtract, otherwise 16-bit add of {hi,lo}+b.
  // Flags: [3] even parity of low byte, [2] N (bit15), [1] carry/borrow, [0] Z.
  logic [15:0] a16;
  logic [16:0] r17;
  always_comb begin
    a16 = {alu_a_hi, alu_a_lo};
    case (alu_oper)
      5'd1:    r17 = {1'b0, a16} - {9'd0, alu_b};
      default: r17 = {1'b0, a16} + {9'd0, alu_b};
    endcase
    alu_out_lo    = r17[7:0];
    alu_out_hi    = r17[15:8];
    alu_flags_out = {~^r17[7:0], r17[15], r17[16], (r17[15:0] == 16'h0000)};
  end

  // Scoreboard of expected register writes, consumed as writes appear.
  typedef struct packed { logic [3:0] idx; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got write r%0d=0x%02h, want no write", wr_idx, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_idx !== e.idx || wr_data !== e.data) begin
          errors++;
          $display("FAIL wr_data: got r%0d=0x%02h, want r%0d=0x%02h", wr_idx, wr_data, e.idx, e.data);
        end
      end
    end
  end

  // Per-cycle observations after an accepted request (index = cycles after T).
  int         obs_done_cyc;
  int         obs_done_cnt;
  logic [15:0] obs_wr_mask;
  logic       obs_ready [16];
  logic [3:0] obs_flags [16];

  task automatic issue(input logic [4:0] oper, input logic pair, input logic nowb,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic bimm, input logic [7:0] imm, input logic hold);
    int w;
    w = 0;
    @(negedge clk);
    while (req_if.req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 50) begin
      errors++;
      $display("FAIL issue_ready: req_ready=%b after 50 cycles, want 1", req_if.req_ready);
    end
    req_if.req_oper    = oper;
    req_if.req_is_pair = pair;
    req_if.req_no_wb   = nowb;
    req_if.req_ra      = ra;
    req_if.req_rb      = rb;
    req_if.req_b_imm   = bimm;
    req_if.req_imm     = imm;
    req_if.req_valid   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_if.req_valid = 1'b0;
  endtask

  // Watch 12 cycles after acceptance; optionally pulse flags_load or rst in one cycle.
  task automatic observe(input int load_cyc, input int rst_cyc, input int drop_cyc);
    obs_done_cyc = -1;
    obs_done_cnt = 0;
    obs_wr_mask  = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      flags_load     = (k == load_cyc);
      flags_load_val = 4'hA;
      rst            = (k == rst_cyc);
      @(negedge clk);
      obs_ready[k] = req_if.req_ready;
      obs_flags[k] = flags;
      if (wr_en === 1'b1) obs_wr_mask[k] = 1'b1;
      if (done === 1'b1) begin
        if (obs_done_cyc < 0) obs_done_cyc = k;
        obs_done_cnt++;
      end
      @(posedge clk);
      #1;
      if (k == drop_cyc) req_if.req_valid = 1'b0;
    end
    flags_load = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (req_if.req_ready !== 1'b1 || flags !== 4'h0 || wr_en !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: ready=%b flags=%h wr_en=%b done=%b, want 1 0 0 0",
                 req_if.req_ready, flags, wr_en, done);
      end
    end
    checks++;
    if (alu_oper !== 5'd0 || alu_a_lo !== 8'h00 || alu_a_hi !== 8'h00 || alu_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_operands: oper=%h a_lo=%h a_hi=%h b=%h, want all 0",
               alu_oper, alu_a_lo, alu_a_hi, alu_b);
    end
  endtask

  task automatic test_add8();
    exp_q.push_back('{idx: 4'd1, data: 8'h4B});
    issue(5'd0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0);
    observe(0, 0, 0);
    checks++;
    if (obs_done_cyc != 4 || obs_done_cnt != 1) begin
      errors++;
      $display("FAIL add8_done: cycle %0d count %0d, want cycle 4 count 1", obs_done_cyc, obs_done_cnt);
    end
    checks++;
    if (obs_wr_mask !== 16'h0010) begin
      errors++;
      $display("FAIL add8_wr_cycle: mask %h, want 0010", obs_wr_mask);
    end
    checks++;
    if (obs_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL add8_busy: req_ready=%b while busy, want 0", obs_ready[2]);
    end
    checks++;
    if (alu_a_lo !== 8'h3C || alu_b !== 8'h0F || alu_a_hi !== 8'h00) begin
      errors++;
      $display("FAIL add8_operands: a_lo=%h a_hi=%h b=%h, want 3c 00 0f", alu_a_lo, alu_a_hi, alu_b);
    end
    checks++;
    if (flags !== 4'h8 || rf[1] !== 8'h4B) begin
      errors++;
      $display("FAIL add8_result: flags=%h r1=%h, want 8 4b", flags, rf[1]);
    end
  endtask

  task automatic test_cmp();
    issue(5'd1, 1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 8'h05, 1'b0);
    observe(0, 0, 0);
    checks++;
    if (obs_done_cyc != 3 || obs_done_cnt != 1) begin
      errors++;
      $display("FAIL cmp_done: cycle %0d count %0d, want cycle 3 count 1", obs_done_cyc, obs_done_cnt);
    end
    checks++;
    if (obs_wr_mask !== 16'h0000) begin
      errors++;
      $display("FAIL cmp_no_write: mask %h, want 0000", obs_wr_mask);
    end
    checks++;
    if (flags !== 4'h9 || alu_flags_in !== 4'h9 || alu_a_lo !== 8'h05 || alu_b !== 8'h05) begin
      errors++;
      $display("FAIL cmp_flags: flags=%h alu_flags_in=%h a_lo=%h b=%h, want 9 9 05 05",
               flags, alu_flags_in, alu_a_lo, alu_b);
    end
  endtask

  task automatic test_pair();
    exp_q.push_back('{idx: 4'd4, data: 8'h30});
    exp_q.push_back('{idx: 4'd5, data: 8'h12});
    issue(5'd1, 1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 8'h04, 1'b0);
    observe(0, 0, 0);
    checks++;
    if (obs_done_cyc != 6 || obs_done_cnt != 1) begin
      errors++;
      $display("FAIL pair_done: cycle %0d count %0d, want cycle 6 count 1", obs_done_cyc, obs_done_cnt);
    end
    checks++;
    if (obs_wr_mask !== 16'h0060) begin
      errors++;
      $display("FAIL pair_wr_cycles: mask %h, want 0060", obs_wr_mask);
    end
    checks++;
    if (alu_a_hi !== 8'h12 || alu_a_lo !== 8'h34 || alu_b !== 8'h04 || flags !== 4'h8) begin
      errors++;
      $display("FAIL pair_operands: a_hi=%h a_lo=%h b=%h flags=%h, want 12 34 04 8",
               alu_a_hi, alu_a_lo, alu_b, flags);
    end
  endtask

  task automatic test_flags_load();
    // Load during EXEC (cycle 3): ALU flags win.
    exp_q.push_back('{idx: 4'd1, data: 8'h5A});
    issue(5'd0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0);
    observe(3, 0, 0);
    checks++;
    if (obs_flags[4] !== 4'h8) begin
      errors++;
      $display("FAIL fload_exec: flags=%h, want 8", obs_flags[4]);
    end
    // Load during RD_B (cycle 2): visible in EXEC, then replaced by ALU flags.
    exp_q.push_back('{idx: 4'd1, data: 8'h69});
    issue(5'd0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0);
    observe(2, 0, 0);
    checks++;
    if (obs_flags[3] !== 4'hA || obs_flags[4] !== 4'h8) begin
      errors++;
      $display("FAIL fload_rdb: flags exec=%h wb=%h, want a 8", obs_flags[3], obs_flags[4]);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{idx: 4'd6, data: 8'h11});
    exp_q.push_back('{idx: 4'd6, data: 8'h12});
    issue(5'd0, 1'b0, 1'b0, 4'd6, 4'd0, 1'b1, 8'h01, 1'b1);
    observe(0, 0, 5);
    checks++;
    if (obs_done_cyc != 4 || obs_done_cnt != 2 || obs_wr_mask !== 16'h0210) begin
      errors++;
      $display("FAIL b2b: first done %0d count %0d wr mask %h, want 4 2 0210",
               obs_done_cyc, obs_done_cnt, obs_wr_mask);
    end
    checks++;
    if (rf[6] !== 8'h12) begin
      errors++;
      $display("FAIL b2b_result: r6=%h, want 12", rf[6]);
    end
  endtask

  task automatic test_reset_mid();
    // Reset in WB_LO (cycle 4): the write of r1 is abandoned.
    issue(5'd0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0);
    observe(0, 4, 0);
    checks++;
    if (obs_done_cnt != 0 || obs_wr_mask !== 16'h0000 || obs_ready[5] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: done count %0d wr mask %h ready %b, want 0 0000 1",
               obs_done_cnt, obs_wr_mask, obs_ready[5]);
    end
    checks++;
    if (rf[1] !== 8'h69) begin
      errors++;
      $display("FAIL rst_mid_reg: r1=%h, want 69", rf[1]);
    end
    exp_q.push_back('{idx: 4'd1, data: 8'h78});
    issue(5'd0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0);
    observe(0, 0, 0);
    checks++;
    if (obs_done_cyc != 4 || obs_done_cnt != 1 || rf[1] !== 8'h78 || flags !== 4'h8) begin
      errors++;
      $display("FAIL rst_recover: done %0d count %0d r1=%h flags=%h, want 4 1 78 8",
               obs_done_cyc, obs_done_cnt, rf[1], flags);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rf[1] = 8'h3C; rf[2] = 8'h0F; rf[3] = 8'h05;
    rf[4] = 8'h34; rf[5] = 8'h12; rf[6] = 8'h10;
    rst = 1'b1;
    flags_load = 1'b0;
    flags_load_val = 4'h0;
    req_if.req_valid = 1'b0;
    req_if.req_oper = 5'd0;
    req_if.req_is_pair = 1'b0;
    req_if.req_no_wb = 1'b0;
    req_if.req_ra = 4'd0;
    req_if.req_rb = 4'd0;
    req_if.req_b_imm = 1'b0;
    req_if.req_imm = 8'h00;

    test_reset();
    test_add8();
    test_cmp();
    test_pair();
    test_flags_load();
    test_back_to_back();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wr_missing: %0d expected writes never seen, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
